// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - MD op encodings, counter width and state type
package md_sequencer_pkg;

  localparam int MD_CNT_W = 5;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide result for one MD op
module md_calc
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Products and sign-magnitude division; the magnitude path makes
  // 0x80000000 / -1 wrap to 0x80000000 with remainder 0 naturally.
  always_comb begin
    prod_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u    = {32'd0, a} * {32'd0, b};
    is_signed = (md_op == MD_DIV);
    a_mag     = (is_signed && a[31]) ? (32'd0 - a) : a;
    b_mag     = (is_signed && b[31]) ? (32'd0 - b) : b;
    // A zero divisor is replaced so the divider never sees 0; the result is discarded.
    b_safe    = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    quot      = (is_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    rem       = (is_signed && a[31]) ? (32'd0 - r_mag) : r_mag;
    div_zero  = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (b == 32'd0);
    res_hi    = 32'd0;
    res_lo    = 32'd0;
    case (md_op)
      MD_MULT:          {res_hi, res_lo} = prod_s;
      MD_MULTU:         {res_hi, res_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_hi = rem;
        res_lo = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle HI/LO sequencer for the shared mult/div unit
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [2:0]          md_op,
  input  logic                flush,
  input  logic [31:0]         src_a,
  input  logic [31:0]         src_b,
  output logic [31:0]         hi_out,
  output logic [31:0]         lo_out,
  output logic [MD_CNT_W-1:0] busy_cnt,
  output logic                busy,
  output logic                done
);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_d;
  logic [31:0]         pend_hi_q, pend_hi_d;
  logic [31:0]         pend_lo_q, pend_lo_d;
  logic                pend_zero_q, pend_zero_d;
  logic [31:0]         hi_d, lo_d;
  logic                done_d;
  logic                accept;
  logic [31:0]         calc_hi, calc_lo;
  logic                calc_zero;

  md_calc u_calc (
    .md_op    (md_op),
    .a        (src_a),
    .b        (src_b),
    .res_hi   (calc_hi),
    .res_lo   (calc_lo),
    .div_zero (calc_zero)
  );

  // A flushed instruction never touches state; starts while busy are dropped.
  assign accept = start & ~flush & (state_q == ST_IDLE);
  assign busy   = (busy_cnt != '0);

  // State register, counter, pending result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      busy_cnt    <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_zero_q <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_cnt    <= cnt_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_zero_q <= pend_zero_d;
      hi_out      <= hi_d;
      lo_out      <= lo_d;
      done        <= done_d;
    end
  end

  // Next-state: accept in IDLE, count down in BUSY, commit on the 1->0 edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = busy_cnt;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_zero_d = pend_zero_q;
    hi_d        = hi_out;
    lo_d        = lo_out;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d     = ST_BUSY;
              cnt_d       = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ?
                            MD_CNT_W'(MULT_CYCLES) : MD_CNT_W'(DIV_CYCLES);
              pend_hi_d   = calc_hi;
              pend_lo_d   = calc_lo;
              pend_zero_d = calc_zero;
            end
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = busy_cnt - MD_CNT_W'(1);
        if (busy_cnt == MD_CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          // Divide-by-zero burns the full latency but leaves HI/LO alone.
          if (!pend_zero_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - randomized scoreboard bench for md_sequencer
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic        flush = 1'b0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic [31:0] hi_out, lo_out;
  logic [4:0]  busy_cnt;
  logic        busy, done;

  md_sequencer #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op), .flush(flush),
    .src_a(src_a), .src_b(src_b), .hi_out(hi_out), .lo_out(lo_out),
    .busy_cnt(busy_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int          m_rem   = 0;
  logic [31:0] m_hi    = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_pzero = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural result of one MD op straight from the arithmetic definition.
  function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output bit z);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    h = 0; l = 0; z = 0;
    case (op)
      MD_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {h, l} = p;
      end
      MD_MULTU: begin
        ua = {32'd0, a}; ub = {32'd0, b};
        pu = ua * ub;
        {h, l} = pu;
      end
      MD_DIV: begin
        if (b == 0) z = 1;
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          l = 32'(sa / sb); h = 32'(sa % sb);
        end
      end
      MD_DIVU: begin
        if (b == 0) z = 1;
        else begin
          ua = {32'd0, a}; ub = {32'd0, b};
          l = 32'(ua / ub); h = 32'(ua % ub);
        end
      end
      default: ;
    endcase
  endfunction

  // Drive one cycle of inputs and push the state expected after the next edge.
  task automatic step(input bit s, input logic [2:0] op, input bit f,
                      input logic [31:0] a, input logic [31:0] b, input bit rn);
    exp_t e;
    @(negedge clk);
    reset_n = rn; start = s; md_op = op; flush = f; src_a = a; src_b = b;
    e.done = 1'b0;
    if (!rn) begin
      m_rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pzero = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        if (!m_pzero) begin m_hi = m_phi; m_lo = m_plo; end
        e.done = 1'b1;
      end
    end else if (s && !f) begin
      case (op)
        MD_MULT, MD_MULTU: begin ref_calc(op, a, b, m_phi, m_plo, m_pzero); m_rem = MULT_CYC; end
        MD_DIV, MD_DIVU:   begin ref_calc(op, a, b, m_phi, m_plo, m_pzero); m_rem = DIV_CYC; end
        MD_MTHI: m_hi = a;
        MD_MTLO: m_lo = a;
        default: ;
      endcase
    end
    e.cnt = m_rem; e.hi = m_hi; e.lo = m_lo;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 3'd0, 0, 32'd0, 32'd0, 1);
  endtask

  task automatic drain();
    while (m_rem > 0) idle();
    idle();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare DUT outputs against the scoreboard one cycle at a time.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy_cnt", 64'(busy_cnt), 64'(e.cnt));
        chk("busy", 64'(busy), 64'(e.cnt != 0));
        chk("hi_out", 64'(hi_out), 64'(e.hi));
        chk("lo_out", 64'(lo_out), 64'(e.lo));
        chk("done", 64'(done), 64'(e.done));
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          s, f;
    #3;
    chk("reset_hi", 64'(hi_out), 64'd0);
    chk("reset_lo", 64'(lo_out), 64'd0);
    chk("reset_cnt", 64'(busy_cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    step(0, 3'd0, 0, 0, 0, 0);
    idle();

    step(1, MD_MULT, 0, 32'hFFFFFFFE, 32'd3, 1);
    drain();
    settle();
    chk("mult_hi", 64'(hi_out), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo_out), 64'hFFFFFFFA);

    step(1, MD_MULTU, 0, 32'hFFFFFFFF, 32'd2, 1);
    drain();
    settle();
    chk("multu_hi", 64'(hi_out), 64'h00000001);
    chk("multu_lo", 64'(lo_out), 64'hFFFFFFFE);

    step(1, MD_DIV, 0, 32'hFFFFFFF9, 32'd2, 1);
    drain();
    settle();
    chk("div_lo", 64'(lo_out), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi_out), 64'hFFFFFFFF);

    step(1, MD_DIVU, 0, 32'h55, 32'd0, 1);
    drain();
    settle();
    chk("divu0_lo", 64'(lo_out), 64'hFFFFFFFD);
    chk("divu0_hi", 64'(hi_out), 64'hFFFFFFFF);

    step(1, MD_MTLO, 1, 32'h1234, 0, 1);
    settle();
    chk("mtlo_flush", 64'(lo_out), 64'hFFFFFFFD);
    step(1, MD_MTLO, 0, 32'h1234, 0, 1);
    settle();
    chk("mtlo", 64'(lo_out), 64'h1234);

    step(1, MD_DIV, 0, 32'h80000000, 32'hFFFFFFFF, 1);
    drain();
    settle();
    chk("div_ovf_lo", 64'(lo_out), 64'h80000000);
    chk("div_ovf_hi", 64'(hi_out), 64'h0);

    step(1, MD_DIV, 0, 32'd100, 32'd7, 1);
    while (m_rem != 4) idle();
    step(1, MD_DIV, 1, 32'd9, 32'd3, 1);
    step(1, MD_MTHI, 0, 32'hDEAD, 0, 1);
    drain();
    settle();
    chk("flush_busy_lo", 64'(lo_out), 64'd14);
    chk("flush_busy_hi", 64'(hi_out), 64'd2);

    step(1, MD_MULT, 0, 32'd7, 32'd9, 1);
    while (m_rem != 2) idle();
    step(0, 3'd0, 0, 0, 0, 0);
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi_out), 64'd0);
    chk("rst_mid_lo", 64'(lo_out), 64'd0);
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 99) < 55);
      f  = ($urandom_range(0, 99) < 20);
      op = 3'($urandom_range(0, 5));
      a  = $urandom();
      b  = ($urandom_range(0, 9) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom());
      if ($urandom_range(0, 2) == 0) a = 32'($signed(32'($urandom_range(0, 200))) - 100);
      step(s, op, f, a, b, ($urandom_range(0, 199) != 0));
    end
    drain();
    settle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
